// File: rtl/map_row_extent.sv
// Row-extent mapper: scans rows mostTop..mostBottom outward from midPix through one
// shared frame-RAM read port and reports the overall leftmost/rightmost object columns.
module map_row_extent #(
    parameter int X_RES     = 160,
    parameter int Y_RES     = 120,
    parameter int X_W       = 8,
    parameter int Y_W       = 7,
    parameter int ADDR_W    = 15,
    parameter int COL_W     = 3,
    parameter int THRESHOLD = 0,
    parameter int RD_LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [Y_W-1:0]    mostTop,
    input  logic [Y_W-1:0]    mostBottom,
    input  logic [X_W-1:0]    midPix,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [COL_W-1:0]  mem_data,
    output logic [X_W-1:0]    mostLeft,
    output logic [X_W-1:0]    mostRight,
    output logic              busy,
    output logic              done,
    output logic              invalid
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        ROW_INIT = 4'd1,
        R_REQ    = 4'd2,
        R_WAIT   = 4'd3,
        R_CHK    = 4'd4,
        L_REQ    = 4'd5,
        L_WAIT   = 4'd6,
        L_CHK    = 4'd7,
        DONE     = 4'd8
    } state_t;

    localparam logic [X_W:0]      X_RES_E = (X_W+1)'(X_RES);
    localparam logic [Y_W:0]      Y_RES_E = (Y_W+1)'(Y_RES);
    localparam logic [X_W-1:0]    X_MAX   = X_W'(X_RES - 1);
    localparam logic [X_W-1:0]    X_ONE   = X_W'(1);
    localparam logic [Y_W-1:0]    Y_ONE   = Y_W'(1);
    localparam logic [1:0]        WAIT_N  = 2'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] X_RES_A = ADDR_W'(X_RES);
    localparam logic [COL_W-1:0]  THR     = COL_W'(THRESHOLD);

    state_t             state_q, state_d;
    logic [X_W-1:0]     x_q, x_d, mid_q, mid_d, left_q, left_d, right_q, right_d;
    logic [Y_W-1:0]     y_q, y_d, top_q, top_d, bot_q, bot_d;
    logic [1:0]         cnt_q, cnt_d;
    logic               inv_q, inv_d, busy_q, busy_d, done_q, done_d, rd_q, rd_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               is_obj_s, end_r_s, adv_s, go_left_s, advance_s, exit_s;

    assign is_obj_s = (mem_data > THR);

    // Next-state, scan-position and extent update logic.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        top_d   = top_q;
        bot_d   = bot_q;
        mid_d   = mid_q;
        left_d  = left_q;
        right_d = right_q;
        cnt_d   = cnt_q;
        inv_d   = inv_q;
        end_r_s = 1'b0;
        adv_s   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    top_d = mostTop;
                    bot_d = mostBottom;
                    mid_d = midPix;
                    if ((mostTop > mostBottom) || ({1'b0, mostBottom} >= Y_RES_E) ||
                        ({1'b0, midPix} >= X_RES_E)) begin
                        inv_d   = 1'b1;
                        state_d = DONE;
                    end else begin
                        inv_d   = 1'b0;
                        left_d  = midPix;
                        right_d = midPix;
                        y_d     = mostTop;
                        state_d = ROW_INIT;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            ROW_INIT: begin
                // No right neighbour: behave as if the right scan just ended.
                if (mid_q == X_MAX) begin
                    end_r_s = 1'b1;
                end else begin
                    x_d     = mid_q + X_ONE;
                    state_d = R_REQ;
                end
            end
            R_REQ: begin
                if (WAIT_N == 2'd0) begin
                    state_d = R_CHK;
                end else begin
                    cnt_d   = WAIT_N;
                    state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (cnt_q == 2'd1) begin
                    state_d = R_CHK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            R_CHK: begin
                if (is_obj_s) begin
                    if (x_q > right_q) begin
                        right_d = x_q;
                    end else begin
                        right_d = right_q;
                    end
                    if (x_q < X_MAX) begin
                        x_d     = x_q + X_ONE;
                        state_d = R_REQ;
                    end else begin
                        end_r_s = 1'b1;
                    end
                end else begin
                    end_r_s = 1'b1;
                end
            end
            L_REQ: begin
                if (WAIT_N == 2'd0) begin
                    state_d = L_CHK;
                end else begin
                    cnt_d   = WAIT_N;
                    state_d = L_WAIT;
                end
            end
            L_WAIT: begin
                if (cnt_q == 2'd1) begin
                    state_d = L_CHK;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            L_CHK: begin
                if (is_obj_s) begin
                    if (x_q < left_q) begin
                        left_d = x_q;
                    end else begin
                        left_d = left_q;
                    end
                    if (x_q != '0) begin
                        x_d     = x_q - X_ONE;
                        state_d = L_REQ;
                    end else begin
                        adv_s = 1'b1;
                    end
                end else begin
                    adv_s = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Row advance uses the extents just updated in this cycle, so a full-width row exits at once.
        go_left_s = end_r_s && (mid_q != '0);
        advance_s = adv_s || (end_r_s && (mid_q == '0));
        exit_s    = (y_q == bot_q) || ((left_d == '0) && (right_d == X_MAX));
        case ({advance_s, go_left_s})
            2'b01: begin
                x_d     = mid_q - X_ONE;
                state_d = L_REQ;
            end
            2'b10: begin
                if (exit_s) begin
                    state_d = DONE;
                end else begin
                    y_d     = y_q + Y_ONE;
                    state_d = ROW_INIT;
                end
            end
            default: begin
                cnt_d = cnt_d;
            end
        endcase
    end

    // Registered output values derived from the upcoming state.
    always_comb begin
        done_d = (state_d == DONE);
        busy_d = (state_d != IDLE) && (state_d != DONE);
        rd_d   = (state_d == R_REQ) || (state_d == L_REQ);
        if (rd_d) begin
            addr_d = (ADDR_W'(y_d) * X_RES_A) + ADDR_W'(x_d);
        end else begin
            addr_d = addr_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            top_q   <= '0;
            bot_q   <= '0;
            mid_q   <= '0;
            left_q  <= '0;
            right_q <= '0;
            cnt_q   <= 2'd0;
            inv_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            top_q   <= top_d;
            bot_q   <= bot_d;
            mid_q   <= mid_d;
            left_q  <= left_d;
            right_q <= right_d;
            cnt_q   <= cnt_d;
            inv_q   <= inv_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_rd    = rd_q;
    assign mostLeft  = left_q;
    assign mostRight = right_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign invalid   = inv_q;

endmodule

// File: tb/tb_map_row_extent.sv
// Directed table-driven bench for map_row_extent: two instances (read latency 1 and 3)
// share one frame image and stimulus, each fed by its own pipelined memory model.
module tb_map_row_extent;

    logic        clk;
    logic        reset;
    logic        start;
    logic [6:0]  mostTop, mostBottom;
    logic [7:0]  midPix;
    logic [14:0] mem_addr1, mem_addr3;
    logic        mem_rd1, mem_rd3;
    logic [2:0]  mem_data1, mem_data3;
    logic [7:0]  left1, right1, left3, right3;
    logic        busy1, busy3, done1, done3, inv1, inv3;

    logic [2:0]  img [0:19199];
    logic [2:0]  q1, p3a, p3b, p3c;

    int n_cmp = 0;
    int n_err = 0;
    int bad1 = 0;
    int bad3 = 0;
    int cur_top = 0, cur_bot = 0, cur_mid = 0, cur_scene = -1;

    typedef struct {
        int scene; int top; int bot; int mid; int poke;
        int exp_l; int exp_r; int exp_inv; int cyc1; int cyc3;
    } vec_t;
    vec_t vt [13];

    map_row_extent dut1 (
        .clk(clk), .reset(reset), .start(start), .mostTop(mostTop), .mostBottom(mostBottom),
        .midPix(midPix), .mem_addr(mem_addr1), .mem_rd(mem_rd1), .mem_data(mem_data1),
        .mostLeft(left1), .mostRight(right1), .busy(busy1), .done(done1), .invalid(inv1)
    );

    map_row_extent #(.RD_LAT(3)) dut3 (
        .clk(clk), .reset(reset), .start(start), .mostTop(mostTop), .mostBottom(mostBottom),
        .midPix(midPix), .mem_addr(mem_addr3), .mem_rd(mem_rd3), .mem_data(mem_data3),
        .mostLeft(left3), .mostRight(right3), .busy(busy3), .done(done3), .invalid(inv3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] rd_img(input logic [14:0] a);
        if (int'(a) < 19200) return img[a];
        return 3'd0;
    endfunction

    function automatic bit addr_ok(input logic [14:0] a);
        int ai = int'(a);
        int row = ai / 160;
        int col = ai % 160;
        return (ai < 19200) && (row >= cur_top) && (row <= cur_bot) && (col != cur_mid);
    endfunction

    // Memory models: data returns 1 or 3 cycles after the read strobe, zero otherwise.
    always @(posedge clk) begin
        q1  <= mem_rd1 ? rd_img(mem_addr1) : 3'd0;
        p3a <= mem_rd3 ? rd_img(mem_addr3) : 3'd0;
        p3b <= p3a;
        p3c <= p3b;
    end
    assign mem_data1 = q1;
    assign mem_data3 = p3c;

    // Read-address monitor: rows inside the scan window, never the seed pixel.
    always @(posedge clk) begin
        if (!reset && mem_rd1 && !addr_ok(mem_addr1)) bad1 = bad1 + 1;
        if (!reset && mem_rd3 && !addr_ok(mem_addr3)) bad3 = bad3 + 1;
    end

    function automatic int dia_h(input int y);
        case (y)
            5: return 2;   6: return 5;   7: return 7;   8: return 10;  9: return 12;
            10: return 10; 11: return 7;  12: return 5;  13: return 2;
            default: return -1;
        endcase
    endfunction

    task automatic build_scene(input int s);
        if (s != cur_scene) begin
            for (int i = 0; i < 19200; i++) img[i] = 3'd0;
            for (int y = 0; y < 120; y++) begin
                for (int x = 0; x < 160; x++) begin
                    if (s == 0 && y >= 10 && y <= 20 && x >= 40 && x <= 60) img[y*160+x] = 3'd5;
                    if (s == 1 && dia_h(y) >= 0 && x >= 32 - dia_h(y) && x <= 32 + dia_h(y))
                        img[y*160+x] = 3'd1;
                    if (s == 2 && y >= 3 && y <= 50) img[y*160+x] = 3'd7;
                end
            end
            cur_scene = s;
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int c1 = -1, c3 = -1, l1 = -1, r1 = -1, i1 = -1, l3 = -1, r3 = -1, i3 = -1;
        int b1, b3;
        build_scene(v.scene);
        cur_top = v.top; cur_bot = v.bot; cur_mid = v.mid;
        b1 = bad1; b3 = bad3;
        @(negedge clk);
        mostTop = 7'(v.top); mostBottom = 7'(v.bot); midPix = 8'(v.mid);
        start = 1'b1;
        for (int c = 1; c <= 3000; c++) begin
            @(posedge clk); #1;
            start = (v.poke != 0 && c == 20);
            if (v.poke != 0 && c == 20) begin
                mostTop = 7'd30; mostBottom = 7'd20; midPix = 8'd0;
            end
            if (done1 && c1 < 0) begin c1 = c; l1 = int'(left1); r1 = int'(right1); i1 = int'(inv1); end
            if (done3 && c3 < 0) begin c3 = c; l3 = int'(left3); r3 = int'(right3); i3 = int'(inv3); end
            if (c1 >= 0 && c3 >= 0) break;
        end
        start = 1'b0;
        chk($sformatf("v%0d lat1 cycles", idx), c1, v.cyc1);
        chk($sformatf("v%0d lat1 mostLeft", idx), l1, v.exp_l);
        chk($sformatf("v%0d lat1 mostRight", idx), r1, v.exp_r);
        chk($sformatf("v%0d lat1 invalid", idx), i1, v.exp_inv);
        chk($sformatf("v%0d lat3 cycles", idx), c3, v.cyc3);
        chk($sformatf("v%0d lat3 mostLeft", idx), l3, v.exp_l);
        chk($sformatf("v%0d lat3 mostRight", idx), r3, v.exp_r);
        chk($sformatf("v%0d lat3 invalid", idx), i3, v.exp_inv);
        chk($sformatf("v%0d lat1 bad reads", idx), bad1 - b1, 0);
        chk($sformatf("v%0d lat3 bad reads", idx), bad3 - b3, 0);
        @(posedge clk); #1;
        chk($sformatf("v%0d done1 pulse", idx), int'(done1), 0);
        chk($sformatf("v%0d done3 pulse", idx), int'(done3), 0);
        chk($sformatf("v%0d busy1 idle", idx), int'(busy1), 0);
        chk($sformatf("v%0d lat1 left held", idx), int'(left1), v.exp_l);
        chk($sformatf("v%0d lat3 right held", idx), int'(right3), v.exp_r);
    endtask

    initial begin
        //        scene top bot mid poke  L    R  inv  cyc1 cyc3
        vt[0]  = '{0, 10, 20,  50, 0,  40,  60, 0, 496, 980};
        vt[1]  = '{0, 10, 10, 100, 0, 100, 100, 0,   6,  10};
        vt[2]  = '{1,  5, 13,  32, 0,  20,  44, 0, 286, 562};
        vt[3]  = '{1,  9,  9,  32, 0,  20,  44, 0,  54, 106};
        vt[4]  = '{1, 10, 13,  32, 0,  22,  42, 0, 117, 229};
        vt[5]  = '{1, 30, 20,  50, 0,  22,  42, 1,   1,   1};
        vt[6]  = '{1, 10, 20, 160, 0,  22,  42, 1,   1,   1};
        vt[7]  = '{1, 10, 120, 50, 0,  22,  42, 1,   1,   1};
        vt[8]  = '{2,  3, 50,  80, 0,   0, 159, 0, 320, 638};
        vt[9]  = '{2,  3, 50,   0, 0,   0, 159, 0, 320, 638};
        vt[10] = '{2,  3, 50, 159, 0,   0, 159, 0, 320, 638};
        vt[11] = '{0, 10, 20,  50, 1,  40,  60, 0, 496, 980};
        vt[12] = '{0, 10, 20,  40, 0,  40,  60, 0, 496, 980};

        reset = 1'b1; start = 1'b0;
        mostTop = 7'd0; mostBottom = 7'd0; midPix = 8'd0;
        #1;
        chk("rst mostLeft", int'(left1), 0);
        chk("rst mostRight", int'(right1), 0);
        chk("rst mem_addr", int'(mem_addr1), 0);
        chk("rst mem_rd", int'(mem_rd1), 0);
        chk("rst busy", int'(busy1), 0);
        chk("rst done", int'(done1), 0);
        chk("rst invalid", int'(inv1), 0);
        chk("rst lat3 busy", int'(busy3), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vt[i], i);

        // Reset in the middle of a scan must clear everything without a clock edge.
        build_scene(0);
        cur_top = 10; cur_bot = 20; cur_mid = 50;
        @(negedge clk);
        mostTop = 7'd10; mostBottom = 7'd20; midPix = 8'd50; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk); #2;
        chk("pre-reset busy1", int'(busy1), 1);
        chk("pre-reset busy3", int'(busy3), 1);
        reset = 1'b1;
        #1;
        chk("async rst mem_rd1", int'(mem_rd1), 0);
        chk("async rst busy1", int'(busy1), 0);
        chk("async rst mem_addr1", int'(mem_addr1), 0);
        chk("async rst mostLeft1", int'(left1), 0);
        chk("async rst mostRight1", int'(right1), 0);
        chk("async rst busy3", int'(busy3), 0);
        chk("async rst mem_addr3", int'(mem_addr3), 0);
        chk("async rst mostRight3", int'(right3), 0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        run_vec(vt[0], 13);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
